// File: rtl/dsp48a1_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dsp48a1_pkg                                                          |
// | Shared widths and operand-mux select codes for the DSP48A1 slice.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dsp48a1_pkg;
    localparam int P_W = 48;
    localparam int M_W = 36;

    localparam logic [1:0] X_ZERO = 2'd0;
    localparam logic [1:0] X_M    = 2'd1;
    localparam logic [1:0] X_P    = 2'd2;
    localparam logic [1:0] X_DAB  = 2'd3;

    localparam logic [1:0] Z_ZERO = 2'd0;
    localparam logic [1:0] Z_PCIN = 2'd1;
    localparam logic [1:0] Z_P    = 2'd2;
    localparam logic [1:0] Z_C    = 2'd3;
endpackage
`default_nettype wire

// File: rtl/dsp_pipe_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dsp_pipe_reg                                                         |
// | Optional pipeline stage: sync reset, clock enable, or pure bypass.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dsp_pipe_reg #(
    parameter int WIDTH  = 1,
    parameter int ENABLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    generate
        if (ENABLE != 0) begin : g_reg
            logic [WIDTH-1:0] r_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q <= '0;
                end else if (ce) begin
                    r_q <= d;
                end
            end
            assign q = r_q;
        end else begin : g_bypass
            // Control inputs are intentionally ignored in bypass mode.
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst, ce};
            assign q = d;
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/dsp_post_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dsp_post_adder                                                       |
// | DSP48A1 X/Z operand muxes, 49-bit add/subtract, P and carry-out.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dsp_post_adder
    import dsp48a1_pkg::*;
#(
    parameter int CREG        = 1,
    parameter int CARRYINREG  = 1,
    parameter int PREG        = 1,
    parameter int CARRYOUTREG = 1,
    parameter     CARRYINSEL  = "OPMODE5"
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce_c,
    input  logic           ce_carryin,
    input  logic           ce_p,
    input  logic [M_W-1:0] m,
    input  logic [P_W-1:0] dab,
    input  logic [P_W-1:0] c,
    input  logic [P_W-1:0] pcin,
    input  logic [7:0]     opmode,
    input  logic           carryin,
    output logic [P_W-1:0] p,
    output logic [P_W-1:0] pcout,
    output logic           carryout,
    output logic           carryoutf
);
    logic [P_W-1:0] c_q;
    logic [P_W-1:0] p_q;
    logic [P_W-1:0] x_mux;
    logic [P_W-1:0] z_mux;
    logic [P_W:0]   sum;
    logic           carry_src;
    logic           cin;
    logic           co_q;
    logic           unused_bits;

    assign unused_bits = ^{opmode[6], opmode[5], opmode[4], carryin};

    generate
        if (CARRYINSEL == "OPMODE5") begin : g_cin_opmode
            assign carry_src = opmode[5];
        end else if (CARRYINSEL == "CARRYIN") begin : g_cin_port
            assign carry_src = carryin;
        end else begin : g_cin_zero
            assign carry_src = 1'b0;
        end
    endgenerate

    dsp_pipe_reg #(.WIDTH(P_W), .ENABLE(CREG)) u_c_reg (
        .clk (clk), .rst (rst), .ce (ce_c), .d (c), .q (c_q)
    );

    dsp_pipe_reg #(.WIDTH(1), .ENABLE(CARRYINREG)) u_cyi_reg (
        .clk (clk), .rst (rst), .ce (ce_carryin), .d (carry_src), .q (cin)
    );

    always_comb begin
        x_mux = '0;
        case (opmode[1:0])
            X_ZERO:  x_mux = '0;
            X_M:     x_mux = {{(P_W-M_W){1'b0}}, m};
            X_P:     x_mux = p_q;
            X_DAB:   x_mux = dab;
            default: x_mux = '0;
        endcase
    end

    always_comb begin
        z_mux = '0;
        case (opmode[3:2])
            Z_ZERO:  z_mux = '0;
            Z_PCIN:  z_mux = pcin;
            Z_P:     z_mux = p_q;
            Z_C:     z_mux = c_q;
            default: z_mux = '0;
        endcase
    end

    // Carry-in joins X before subtraction, so sum[48] reads as a borrow.
    always_comb begin
        sum = '0;
        if (opmode[7]) begin
            sum = {1'b0, z_mux} - ({1'b0, x_mux} + {{P_W{1'b0}}, cin});
        end else begin
            sum = {1'b0, z_mux} + {1'b0, x_mux} + {{P_W{1'b0}}, cin};
        end
    end

    dsp_pipe_reg #(.WIDTH(P_W), .ENABLE(PREG)) u_p_reg (
        .clk (clk), .rst (rst), .ce (ce_p), .d (sum[P_W-1:0]), .q (p_q)
    );

    dsp_pipe_reg #(.WIDTH(1), .ENABLE(CARRYOUTREG)) u_co_reg (
        .clk (clk), .rst (rst), .ce (ce_p), .d (sum[P_W]), .q (co_q)
    );

    assign p         = p_q;
    assign pcout     = p_q;
    assign carryout  = co_q;
    assign carryoutf = co_q;
endmodule
`default_nettype wire

// File: tb/tb_dsp_post_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dsp_post_adder                                                    |
// | Directed + random bench with an arithmetic reference model.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dsp_post_adder;
    logic        clk = 1'b0;
    logic        rst, ce_c, ce_carryin, ce_p, carryin;
    logic [35:0] m;
    logic [47:0] dab, c, pcin;
    logic [7:0]  opmode;

    logic [47:0] p0, pc0, p1, pc1;
    logic        co0, cof0, co1, cof1;

    int checks = 0;
    int errors = 0;

    // Reference state: index 0 = OPMODE5 carry source, 1 = CARRYIN port.
    logic [47:0] mdl_c;
    logic        mdl_cy [2];
    logic [47:0] mdl_p  [2];
    logic        mdl_co [2];

    always #5 clk = ~clk;

    dsp_post_adder u_dut (
        .clk (clk), .rst (rst), .ce_c (ce_c), .ce_carryin (ce_carryin),
        .ce_p (ce_p), .m (m), .dab (dab), .c (c), .pcin (pcin),
        .opmode (opmode), .carryin (carryin), .p (p0), .pcout (pc0),
        .carryout (co0), .carryoutf (cof0)
    );

    dsp_post_adder #(.CARRYINSEL("CARRYIN")) u_dut_ci (
        .clk (clk), .rst (rst), .ce_c (ce_c), .ce_carryin (ce_carryin),
        .ce_p (ce_p), .m (m), .dab (dab), .c (c), .pcin (pcin),
        .opmode (opmode), .carryin (carryin), .p (p1), .pcout (pc1),
        .carryout (co1), .carryoutf (cof1)
    );

    always @(posedge clk) begin
        logic [48:0] x, z, s;
        if (rst) begin
            mdl_c = '0;
            for (int i = 0; i < 2; i++) begin
                mdl_cy[i] = 1'b0; mdl_p[i] = '0; mdl_co[i] = 1'b0;
            end
        end else begin
            if (ce_p) begin
                for (int i = 0; i < 2; i++) begin
                    case (opmode[1:0])
                        2'd0: x = 49'd0;
                        2'd1: x = {13'd0, m};
                        2'd2: x = {1'b0, mdl_p[i]};
                        default: x = {1'b0, dab};
                    endcase
                    case (opmode[3:2])
                        2'd0: z = 49'd0;
                        2'd1: z = {1'b0, pcin};
                        2'd2: z = {1'b0, mdl_p[i]};
                        default: z = {1'b0, mdl_c};
                    endcase
                    s = opmode[7] ? z - x - 49'(mdl_cy[i]) : z + x + 49'(mdl_cy[i]);
                    mdl_p[i]  = s[47:0];
                    mdl_co[i] = s[48];
                end
            end
            if (ce_c) mdl_c = c;
            if (ce_carryin) begin
                mdl_cy[0] = opmode[5];
                mdl_cy[1] = carryin;
            end
        end
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every-cycle comparison of both DUTs against the model.
    task automatic step();
        @(posedge clk);
        #1;
        chk("p0",    p0,           mdl_p[0]);
        chk("pc0",   pc0,          mdl_p[0]);
        chk("co0",   48'(co0),     48'(mdl_co[0]));
        chk("cof0",  48'(cof0),    48'(mdl_co[0]));
        chk("p1",    p1,           mdl_p[1]);
        chk("pc1",   pc1,          mdl_p[1]);
        chk("co1",   48'(co1),     48'(mdl_co[1]));
        chk("cof1",  48'(cof1),    48'(mdl_co[1]));
    endtask

    // Literal expectation pinned against both the DUT and the model.
    task automatic lit(input string name, input logic [47:0] pv, input logic cov);
        chk({name, "_p"},      p0,              pv);
        chk({name, "_co"},     48'(co0),        48'(cov));
        chk({name, "_mdl_p"},  mdl_p[0],        pv);
        chk({name, "_mdl_co"}, 48'(mdl_co[0]),  48'(cov));
    endtask

    initial begin
        rst = 1'b1; ce_c = 1'b1; ce_carryin = 1'b1; ce_p = 1'b1; carryin = 1'b0;
        m = '0; dab = '0; c = '0; pcin = '0; opmode = '0;
        #1;
        step(); step();
        lit("reset", 48'd0, 1'b0);
        chk("reset_pcout", pc0, 48'd0);
        chk("reset_cof", 48'(cof0), 48'd0);

        // M + C, C one cycle ahead of M
        rst = 1'b0; c = 48'd10; opmode = 8'h00;
        step();
        m = 36'd6; opmode = 8'b0000_1101;
        step();
        lit("m_plus_c", 48'd16, 1'b0);

        // Accumulate, hold, reset mid-stream
        rst = 1'b1; step();
        rst = 1'b0; m = 36'd5; opmode = 8'b0000_1001;
        step(); lit("acc1", 48'd5, 1'b0);
        step(); lit("acc2", 48'd10, 1'b0);
        step(); lit("acc3", 48'd15, 1'b0);
        ce_p = 1'b0;
        step(); lit("hold1", 48'd15, 1'b0);
        step(); lit("hold2", 48'd15, 1'b0);
        rst = 1'b1; ce_p = 1'b1;
        step(); lit("acc_rst", 48'd0, 1'b0);
        rst = 1'b0;
        step(); lit("acc_restart", 48'd5, 1'b0);

        // Subtract with carry-in, then borrow
        c = 48'd100; opmode = 8'b0010_0000;
        step();
        m = 36'd30; opmode = 8'b1010_1101;
        step(); lit("sub", 48'd69, 1'b0);
        c = 48'd0; opmode = 8'h00;
        step();
        m = 36'd1; opmode = 8'b1000_1101;
        step(); lit("borrow", 48'hFFFF_FFFF_FFFF, 1'b1);

        // Carry-out on add overflow
        dab = 48'hFFFF_FFFF_FFFF; pcin = 48'd1; opmode = 8'b0000_0111;
        step(); lit("carry_add", 48'd0, 1'b1);
        chk("carry_add_cof", 48'(cof0), 48'd1);

        // External carry-in source
        carryin = 1'b1;
        step();
        opmode = 8'h00; carryin = 1'b0;
        step();
        chk("carryin_p1", p1, 48'd1);
        chk("carryin_p0", p0, 48'd0);
        rst = 1'b1; step();
        rst = 1'b0; ce_carryin = 1'b0; carryin = 1'b1;
        step(); step();
        chk("carryin_gated", p1, 48'd0);
        ce_carryin = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 31) == 0);
            ce_c       = ($urandom_range(0, 7) != 0);
            ce_carryin = ($urandom_range(0, 7) != 0);
            ce_p       = ($urandom_range(0, 7) != 0);
            carryin    = 1'($urandom);
            opmode     = 8'($urandom);
            m          = {4'($urandom), 32'($urandom)};
            dab        = ($urandom_range(0, 7) == 0) ? 48'hFFFF_FFFF_FFFF
                                                     : {16'($urandom), 32'($urandom)};
            c          = {16'($urandom), 32'($urandom)};
            pcin       = ($urandom_range(0, 7) == 0) ? 48'd0
                                                     : {16'($urandom), 32'($urandom)};
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dsp_post_adder.md
# dsp_post_adder

Post-adder/accumulator stage of the DSP48A1 slice, directly downstream of the multiplier's M register. It selects X and Z operands through OPMODE-controlled muxes and adds or subtracts them with a selectable carry-in. The result is registered into P, with cascade (PCOUT) and carry-out outputs. Together with the pre-adder/multiplier stages it completes the slice datapath.

## Interface

Parameters:
- CREG, 1: 1 = C operand registered, 0 = combinational bypass.
- CARRYINREG, 1: 1 = carry-in (CYI) registered, 0 = bypass.
- PREG, 1: 1 = P registered, 0 = bypass.
- CARRYOUTREG, 1: 1 = carry-out registered, 0 = bypass.
- CARRYINSEL, "OPMODE5": carry source. "OPMODE5" uses opmode[5]; "CARRYIN" uses the carryin port. Any other value forces the carry source to 0.

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- rst  in  1  reset, synchronous, active-high; clock clk. Clears every register in the block.
- ce_c  in  1  clock enable, C register.
- ce_carryin  in  1  clock enable, CYI register.
- ce_p  in  1  clock enable, P and carry-out registers.
- m  in  36  multiplier product, already registered upstream.
- dab  in  48  concatenation {D[11:0], A[17:0], B[17:0]}, formed upstream.
- c  in  48  C operand.
- pcin  in  48  cascade input from the previous slice.
- opmode  in  8  opmode, already registered upstream.
- carryin  in  1  external carry-in.
- p  out  48  result.
- pcout  out  48  cascade output; identical to p.
- carryout  out  1  carry/borrow out.
- carryoutf  out  1  fabric copy of carryout.

## Operation

- X mux, opmode[1:0]:
  - 0: zero.
  - 1: m zero-extended to 48 bits.
  - 2: P feedback.
  - 3: dab.
- Z mux, opmode[3:2]:
  - 0: zero.
  - 1: pcin.
  - 2: P feedback.
  - 3: C (the CREG stage output).
- cin is the CYI stage output, sourced per CARRYINSEL.
- Arithmetic is 49-bit unsigned:
  - opmode[7]=0: sum = {0,Z} + {0,X} + cin.
  - opmode[7]=1: sum = {0,Z} − ({0,X} + cin).
- P takes sum[47:0]. Carry-out takes sum[48], which is the borrow flag when subtracting.
- Wrap-around is modulo 2^48. There is no saturation.
- P feedback with PREG=0 is a combinational loop. Opmodes selecting P with PREG=0 are unsupported, and the bench excludes them.
- Disabled CE holds the register. rst has priority over CE.

## Timing

- The CREG and CYI stages sit in parallel with the upstream M register:
  - c and the carry source are captured at edge k.
  - m, dab, pcin, opmode[1:0], opmode[3:2] and opmode[7] are used combinationally and sampled into P at edge k+1.
  - The bench therefore drives c and the carry source one cycle before the m they pair with.
- Latency with all registers enabled: m → p is 1 cycle; c → p is 2 cycles.
- Carry-out is registered with the same ce_p and the same edge as P.
- Accumulate (X=M, Z=P) issues one add per cycle with no bubbles.
- Reset values: p=0, pcout=0, carryout=0, carryoutf=0, C stage=0, CYI=0.
- rst asserted mid-accumulate zeroes P on that edge. The next enabled edge computes from P=0.
- Parameter 0 makes the corresponding stage combinational with zero latency. The outputs then follow the inputs within the same cycle.

## Structure

- Shared package dsp48a1_pkg holds:
  - the X-mux select constants (X_ZERO, X_M, X_P, X_DAB);
  - the Z-mux select constants (Z_ZERO, Z_PCIN, Z_P, Z_C);
  - the width constants (P_W=48, M_W=36).
- One sub-module, dsp_pipe_reg. It is parameterised by width and enable, performs sync reset and CE gating, and bypasses when disabled. It is instantiated four times: C, CYI, P and carry-out.
- The muxes and the 49-bit adder are inline combinational logic.

## Test plan

1. Reset: rst=1 with all CEs high for 2 cycles → p=0, pcout=0, carryout=0, carryoutf=0.
2. M+C: c=48'd10 at edge k; m=36'd6, opmode=8'b0000_1101 at edge k+1 → p=16 after edge k+1, carryout=0.
3. Accumulate: m=36'd5 held, opmode=8'b0000_1001 → p = 5, 10, 15 on successive edges. Then ce_p=0 for 2 cycles → p holds 15. Then rst=1 → p=0. Release rst → p=5.
4. Subtract with borrow:
   - c=100, CARRYINSEL="OPMODE5", opmode[5]=1 captured by CYI; m=30, opmode=8'b1010_1101 → p=69, carryout=0.
   - Repeat with c=0, m=1, carry 0 → p=48'hFFFF_FFFF_FFFF, carryout=1.
5. Carry-out add: dab=48'hFFFF_FFFF_FFFF, pcin=1, opmode=8'b0000_0111 → p=0, carryout=1, carryoutf=1.
6. CARRYINSEL="CARRYIN": carryin=1 captured at edge k; opmode X=zero, Z=zero, add → p=1 at edge k+1. With ce_carryin=0 held after reset → p=0.
